// File: rtl/smallmul_seq_pkg.sv
// smallmul_seq_pkg: FSM states, default parameters and carry sizing for the constant multiplier
package smallmul_seq_pkg;
    localparam int DEF_DIGIT_WIDTH = 3;
    localparam int DEF_NB_DIGITS = 8;
    localparam int DEF_MULT_VALUE = 5;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
    function automatic int carry_bits(input int m);
        return $clog2(m);
    endfunction
endpackage

// File: rtl/smallmul_seq_if.sv
// smallmul_seq_if: operand-in / product-out valid-ready handshake bundle
interface smallmul_seq_if #(
    parameter int DATA_W = 24,
    parameter int CARRY_W = 3
);
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [DATA_W+CARRY_W-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/smallmul_seq_lut.sv
// smallmul_seq_lut: per-digit digit*MULT_VALUE + carry, split into product digit and carry out
module smallmul_seq_lut #(
    parameter int DIGIT_WIDTH = 3,
    parameter int MULT_VALUE = 5,
    parameter int CARRY_WIDTH = 3
) (
    input  logic [DIGIT_WIDTH-1:0] digit,
    input  logic [CARRY_WIDTH-1:0] carry_in,
    output logic [DIGIT_WIDTH-1:0] product_digit,
    output logic [CARRY_WIDTH-1:0] carry_out
);
    localparam int PW = DIGIT_WIDTH + CARRY_WIDTH;
    logic [PW-1:0] prod;
    // the sum never exceeds 2^D*M-1, so the carry always fits CARRY_WIDTH
    assign prod = PW'(digit) * PW'(MULT_VALUE) + PW'(carry_in);
    assign {carry_out, product_digit} = prod;
endmodule

// File: rtl/smallmul_seq.sv
// smallmul_seq: digit-serial (LSB first) multiplier of a wide operand by a small constant
module smallmul_seq
    import smallmul_seq_pkg::*;
#(
    parameter int DIGIT_WIDTH = DEF_DIGIT_WIDTH,
    parameter int NB_DIGITS = DEF_NB_DIGITS,
    parameter int MULT_VALUE = DEF_MULT_VALUE,
    parameter int CARRY_WIDTH = carry_bits(MULT_VALUE)
) (
    input logic clk,
    input logic rst,
    smallmul_seq_if.slave bus
);
    localparam int W = NB_DIGITS * DIGIT_WIDTH;
    localparam int CNT_W = $clog2(NB_DIGITS) + 1;
    if (MULT_VALUE < 2 || CARRY_WIDTH > DIGIT_WIDTH) begin : g_bad_params
        $error("smallmul_seq: MULT_VALUE must be >= 2 and CARRY_WIDTH <= DIGIT_WIDTH");
    end
    state_t state, state_n;
    logic [W-1:0] opnd, res;
    logic [CARRY_WIDTH-1:0] carry, carry_n;
    logic [DIGIT_WIDTH-1:0] pdigit;
    logic [CNT_W-1:0] cnt;
    logic last;
    assign last = cnt == CNT_W'(NB_DIGITS - 1);
    assign bus.out_data = {carry, res};
    smallmul_seq_lut #(
        .DIGIT_WIDTH(DIGIT_WIDTH),
        .MULT_VALUE(MULT_VALUE),
        .CARRY_WIDTH(CARRY_WIDTH)
    ) u_lut (
        .digit(opnd[DIGIT_WIDTH-1:0]),
        .carry_in(carry),
        .product_digit(pdigit),
        .carry_out(carry_n)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else state <= state_n;
    end
    // next state and handshake outputs
    always_comb begin
        state_n = state;
        bus.in_ready = state == ST_IDLE;
        bus.out_valid = state == ST_DONE;
        case (state)
            ST_IDLE: if (bus.in_valid) state_n = ST_BUSY;
            ST_BUSY: if (last) state_n = ST_DONE;
            ST_DONE: if (bus.out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end
    // operand/result shift registers, carry and digit counter; product digits enter from the MSB side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd <= '0;
            res <= '0;
            carry <= '0;
            cnt <= '0;
        end else if (state == ST_IDLE && bus.in_valid) begin
            opnd <= bus.in_data;
            res <= '0;
            carry <= '0;
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            opnd <= opnd >> DIGIT_WIDTH;
            res <= (res >> DIGIT_WIDTH) | (W'(pdigit) << (W - DIGIT_WIDTH));
            carry <= carry_n;
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_smallmul_seq.sv
// tb_smallmul_seq: vectors, random and corner sequences against an arithmetic model
module tb_smallmul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    smallmul_seq_if #(.DATA_W(24), .CARRY_W(3)) bus();
    smallmul_seq_if #(.DATA_W(24), .CARRY_W(2)) bus3();
    smallmul_seq_if #(.DATA_W(24), .CARRY_W(3)) bus7();

    smallmul_seq #(.DIGIT_WIDTH(3), .NB_DIGITS(8), .MULT_VALUE(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    smallmul_seq #(.DIGIT_WIDTH(3), .NB_DIGITS(8), .MULT_VALUE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    smallmul_seq #(.DIGIT_WIDTH(3), .NB_DIGITS(8), .MULT_VALUE(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7.slave));

    typedef struct {
        logic [23:0] a;
        logic [26:0] p;
    } vec_t;
    vec_t vecs[6];
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [63:0] model(input logic [23:0] a, input int m);
        return 64'(a) * 64'(m);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // latency counts edges from the accept edge (inclusive) to the first edge after which out_valid is seen
    task automatic run_op(input logic [23:0] a, output logic [26:0] res, output int lat);
        int n = 0;
        while (!bus.in_ready && n < 30) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_data = a;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        res = bus.out_data;
        check("op_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] got;
        logic [23:0] a;
        logic [63:0] q[$];
        int lat, n, last_hs, n_res;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
        bus7.in_valid = 1'b0; bus7.in_data = '0; bus7.out_ready = 1'b0;
        vecs[0] = '{24'd0, 27'd0};
        vecs[1] = '{24'hFFFFFF, 27'h4FFFFFB};
        vecs[2] = '{24'd123, 27'd615};
        vecs[3] = '{24'd1, 27'd5};
        vecs[4] = '{24'd7, 27'd35};
        vecs[5] = '{24'h800000, 27'h2800000};

        #2;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, got, lat);
            check($sformatf("vec%0d_data", i), 64'(got), 64'(vecs[i].p));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
        end

        for (int i = 0; i < 1000; i++) begin
            a = 24'($urandom);
            run_op(a, got, lat);
            check("rand_data", 64'(got), model(a, 5));
        end

        bus.in_valid = 1'b1;
        bus.in_data = 24'd123;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        bus.in_valid = 1'b1;
        bus.in_data = 24'd999;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_data", 64'(bus.out_data), model(24'd123, 5));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_drop_valid", 64'(bus.out_valid), 64'd0);
        check("bp_idle_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("bp_no_extra_accept", 64'(bus.in_ready), 64'd1);

        bus.in_valid = 1'b1;
        bus.in_data = 24'hABCDEF;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_data", 64'(bus.out_data), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op(24'd7, got, lat);
        check("after_abort_data", 64'(got), model(24'd7, 5));

        last_hs = -1;
        n_res = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            bus.in_valid = cyc < 40;
            bus.in_data = 24'($urandom);
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_data, 5));
            if (bus.out_valid) begin
                check("b2b_pending", 64'(q.size()), 64'd1);
                if (q.size() > 0) check("b2b_data", 64'(bus.out_data), q.pop_front());
                if (last_hs >= 0) check("b2b_spacing", 64'(cyc - last_hs), 64'd10);
                last_hs = cyc;
                n_res++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_results", 64'(n_res), 64'd4);
        check("b2b_drained", 64'(q.size()), 64'd0);
        tick();

        bus3.in_valid = 1'b1;
        bus3.in_data = 24'hFFFFFF;
        bus7.in_valid = 1'b1;
        bus7.in_data = 24'hFFFFFF;
        tick();
        bus3.in_valid = 1'b0;
        bus7.in_valid = 1'b0;
        n = 0;
        while (!(bus3.out_valid && bus7.out_valid) && n < 30) begin
            tick();
            n++;
        end
        check("m3_out_valid", 64'(bus3.out_valid), 64'd1);
        check("m7_out_valid", 64'(bus7.out_valid), 64'd1);
        check("m3_max", 64'(bus3.out_data), model(24'hFFFFFF, 3));
        check("m7_max", 64'(bus7.out_data), model(24'hFFFFFF, 7));
        bus3.out_ready = 1'b1;
        bus7.out_ready = 1'b1;
        tick();
        bus3.out_ready = 1'b0;
        bus7.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
